// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS control unit and its datapath.
interface mc_ctrl_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        flow;
    logic        PCWr;
    logic        IRWr;
    logic [1:0]  RegDst;
    logic        ALUSrc;
    logic        RegWr;
    logic [1:0]  MemtoReg;
    logic        MemWrite;
    logic        nPC_sel;
    logic [1:0]  Ext_Op;
    logic [1:0]  ALUctr;
    logic [1:0]  pc_sel;
    logic [1:0]  alu_sel;
    logic        addi_sel;
    logic        illegal;
    logic [31:0] icount;

    modport master (
        input  opcode, funct, zero, flow,
        output PCWr, IRWr, RegDst, ALUSrc, RegWr, MemtoReg, MemWrite, nPC_sel,
               Ext_Op, ALUctr, pc_sel, alu_sel, addi_sel, illegal, icount
    );

    modport slave (
        output opcode, funct, zero, flow,
        input  PCWr, IRWr, RegDst, ALUSrc, RegWr, MemtoReg, MemWrite, nPC_sel,
               Ext_Op, ALUctr, pc_sel, alu_sel, addi_sel, illegal, icount
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving
// the shared-ALU datapath, with illegal-instruction pulse and retire counter.
//   state  | meaning
//   FETCH  | load IR, PC <= PC+4
//   DECODE | classify; jumps complete here, illegal pulses here
//   EXEC   | ALU operation; beq completes here
//   MEM    | data memory access (lw/sw)
//   WB     | register file write
module mc_ctrl (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_SLT, I_JR, I_ORI, I_LUI, I_ADDI,
        I_LW, I_SW, I_BEQ, I_J, I_JAL, I_BAD
    } instr_e;

    state_e      state_q, state_d;
    logic [31:0] icount_q, icount_d;
    instr_e      instr;
    logic        retire;

    logic       pc_wr, ir_wr, alu_src, reg_wr, mem_write, npc_sel, addi_sel, illegal;
    logic [1:0] reg_dst, mem_to_reg, ext_op, alu_ctr, pc_sel, alu_sel;

    // npc qualifies beq with zero itself; the controller never looks at it.
    logic unused_zero;
    assign unused_zero = bus.zero;

    always_comb begin
        instr = I_BAD;
        case (bus.opcode)
            6'b000000: begin
                case (bus.funct)
                    6'b100001: instr = I_ADDU;
                    6'b100011: instr = I_SUBU;
                    6'b101010: instr = I_SLT;
                    6'b001000: instr = I_JR;
                    default:   instr = I_BAD;
                endcase
            end
            6'b001101: instr = I_ORI;
            6'b001111: instr = I_LUI;
            6'b001000: instr = I_ADDI;
            6'b100011: instr = I_LW;
            6'b101011: instr = I_SW;
            6'b000100: instr = I_BEQ;
            6'b000010: instr = I_J;
            6'b000011: instr = I_JAL;
            default:   instr = I_BAD;
        endcase
    end

    always_comb begin
        state_d    = S_FETCH;
        retire     = 1'b0;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_dst    = 2'b00;
        alu_src    = 1'b0;
        reg_wr     = 1'b0;
        mem_to_reg = 2'b00;
        mem_write  = 1'b0;
        npc_sel    = 1'b0;
        ext_op     = 2'b00;
        alu_ctr    = 2'b00;
        pc_sel     = 2'b00;
        alu_sel    = 2'b00;
        addi_sel   = 1'b0;
        illegal    = 1'b0;

        // ALU setup is established in EXEC and held through MEM/WB.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (instr)
                I_SUBU: alu_ctr = 2'b01;
                I_SLT:  alu_ctr = 2'b11;
                I_BEQ:  alu_ctr = 2'b01;
                I_ORI: begin
                    alu_src = 1'b1;
                    alu_ctr = 2'b10;
                end
                I_LUI: begin
                    alu_src = 1'b1;
                    ext_op  = 2'b10;
                    alu_sel = 2'b01;
                end
                I_ADDI: begin
                    alu_src  = 1'b1;
                    ext_op   = 2'b01;
                    addi_sel = 1'b1;
                end
                I_LW, I_SW: begin
                    alu_src = 1'b1;
                    ext_op  = 2'b01;
                end
                default: ;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                ir_wr   = 1'b1;
                pc_wr   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (instr)
                    I_J: begin
                        pc_wr  = 1'b1;
                        pc_sel = 2'b10;
                        retire = 1'b1;
                    end
                    I_JAL: begin
                        pc_wr      = 1'b1;
                        pc_sel     = 2'b10;
                        reg_wr     = 1'b1;
                        reg_dst    = 2'b11;
                        mem_to_reg = 2'b10;
                        retire     = 1'b1;
                    end
                    I_JR: begin
                        pc_wr  = 1'b1;
                        pc_sel = 2'b11;
                        retire = 1'b1;
                    end
                    I_BAD:   illegal = 1'b1;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (instr)
                    I_LW, I_SW: state_d = S_MEM;
                    I_BEQ: begin
                        npc_sel = 1'b1;
                        pc_sel  = 2'b01;
                        pc_wr   = 1'b1;
                        retire  = 1'b1;
                    end
                    I_ADDU, I_SUBU, I_SLT, I_ORI, I_LUI, I_ADDI: state_d = S_WB;
                    default: ;
                endcase
            end
            S_MEM: begin
                if (instr == I_SW) begin
                    mem_write = 1'b1;
                    retire    = 1'b1;
                end else if (instr == I_LW) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                reg_wr = 1'b1;
                retire = 1'b1;
                case (instr)
                    I_ADDU, I_SUBU, I_SLT: reg_dst    = 2'b01;
                    I_LW:                  mem_to_reg = 2'b01;
                    I_ADDI:                reg_dst    = bus.flow ? 2'b10 : 2'b00;
                    default: ;
                endcase
            end
            default: state_d = S_FETCH;
        endcase

        // Reset gates every output combinationally so nothing strobes while rst is low.
        if (!rst) begin
            pc_wr      = 1'b0;
            ir_wr      = 1'b0;
            reg_dst    = 2'b00;
            alu_src    = 1'b0;
            reg_wr     = 1'b0;
            mem_to_reg = 2'b00;
            mem_write  = 1'b0;
            npc_sel    = 1'b0;
            ext_op     = 2'b00;
            alu_ctr    = 2'b00;
            pc_sel     = 2'b00;
            alu_sel    = 2'b00;
            addi_sel   = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign icount_d = icount_q + {31'd0, retire};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
        end
    end

    assign bus.PCWr     = pc_wr;
    assign bus.IRWr     = ir_wr;
    assign bus.RegDst   = reg_dst;
    assign bus.ALUSrc   = alu_src;
    assign bus.RegWr    = reg_wr;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.MemWrite = mem_write;
    assign bus.nPC_sel  = npc_sel;
    assign bus.Ext_Op   = ext_op;
    assign bus.ALUctr   = alu_ctr;
    assign bus.pc_sel   = pc_sel;
    assign bus.alu_sel  = alu_sel;
    assign bus.addi_sel = addi_sel;
    assign bus.illegal  = illegal;
    assign bus.icount   = icount_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction control-word tables fed
// through a scoreboard queue, plus reset / flow / abort sequences.
module tb_mc_ctrl;
    logic clk;
    logic rst;
    mc_ctrl_if bus_if();

    mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]       op;
        logic [5:0]       fn;
        logic             zero;
        logic             flow;
        int               ncyc;
        logic             retire;
        logic [4:0][19:0] exp;
    } vec_t;

    typedef struct packed {
        logic [19:0] w;
        logic [31:0] ic;
    } exp_t;

    vec_t  vecs[20];
    string vnames[20];
    int    nv = 0;
    exp_t  sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    logic [31:0] exp_ic = 0;

    // {PCWr,IRWr,RegDst,ALUSrc,RegWr,MemtoReg,MemWrite,nPC_sel,Ext_Op,ALUctr,pc_sel,alu_sel,addi_sel,illegal}
    logic [19:0] act_w;
    assign act_w = {bus_if.PCWr, bus_if.IRWr, bus_if.RegDst, bus_if.ALUSrc, bus_if.RegWr,
                    bus_if.MemtoReg, bus_if.MemWrite, bus_if.nPC_sel, bus_if.Ext_Op,
                    bus_if.ALUctr, bus_if.pc_sel, bus_if.alu_sel, bus_if.addi_sel, bus_if.illegal};

    function automatic logic [19:0] cw(input logic pcwr, input logic irwr, input logic [1:0] regdst,
                                       input logic alusrc, input logic regwr, input logic [1:0] m2r,
                                       input logic memwr, input logic npc, input logic [1:0] ext,
                                       input logic [1:0] aluctr, input logic [1:0] pcsel,
                                       input logic [1:0] alusel, input logic addisel, input logic ill);
        return {pcwr, irwr, regdst, alusrc, regwr, m2r, memwr, npc, ext, aluctr, pcsel, alusel, addisel, ill};
    endfunction

    task automatic add_vec(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic zero, input logic flow, input int ncyc, input logic retire,
                           input logic [19:0] e0, input logic [19:0] e1, input logic [19:0] e2,
                           input logic [19:0] e3, input logic [19:0] e4);
        vecs[nv].op     = op;
        vecs[nv].fn     = fn;
        vecs[nv].zero   = zero;
        vecs[nv].flow   = flow;
        vecs[nv].ncyc   = ncyc;
        vecs[nv].retire = retire;
        vecs[nv].exp    = {e4, e3, e2, e1, e0};
        vnames[nv]      = name;
        nv++;
    endtask

    task automatic check(input string name, input logic [19:0] w_exp, input logic [31:0] ic_exp);
        n_vec++;
        if (act_w !== w_exp || bus_if.icount !== ic_exp) begin
            n_err++;
            $display("FAIL %s: got ctrl=%05h icount=%0d, expected ctrl=%05h icount=%0d",
                     name, act_w, bus_if.icount, w_exp, ic_exp);
        end
    endtask

    task automatic run_vec(input int i);
        exp_t e;
        bus_if.opcode = vecs[i].op;
        bus_if.funct  = vecs[i].fn;
        bus_if.zero   = vecs[i].zero;
        bus_if.flow   = vecs[i].flow;
        for (int k = 0; k < vecs[i].ncyc; k++) begin
            e.w  = vecs[i].exp[k];
            e.ic = exp_ic;
            sb.push_back(e);
        end
        for (int k = 0; k < vecs[i].ncyc; k++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: scoreboard empty at cycle %0d, expected an entry", vnames[i], k);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s[c%0d]", vnames[i], k), e.w, e.ic);
            end
            @(posedge clk);
            #1;
        end
        if (vecs[i].retire) exp_ic++;
    endtask

    logic [19:0] F, Z, E_LS, E_BEQ, E_ORI, E_LUI, E_ADDI;

    initial begin
        F      = cw(1,1,2'b00,0,0,2'b00,0,0,2'b00,2'b00,2'b00,2'b00,0,0);
        Z      = '0;
        E_LS   = cw(0,0,2'b00,1,0,2'b00,0,0,2'b01,2'b00,2'b00,2'b00,0,0);
        E_BEQ  = cw(1,0,2'b00,0,0,2'b00,0,1,2'b00,2'b01,2'b01,2'b00,0,0);
        E_ORI  = cw(0,0,2'b00,1,0,2'b00,0,0,2'b00,2'b10,2'b00,2'b00,0,0);
        E_LUI  = cw(0,0,2'b00,1,0,2'b00,0,0,2'b10,2'b00,2'b00,2'b01,0,0);
        E_ADDI = cw(0,0,2'b00,1,0,2'b00,0,0,2'b01,2'b00,2'b00,2'b00,1,0);

        add_vec("addu", 6'b000000, 6'b100001, 0, 0, 4, 1, F, Z, Z,
                cw(0,0,2'b01,0,1,2'b00,0,0,2'b00,2'b00,2'b00,2'b00,0,0), Z);
        add_vec("subu", 6'b000000, 6'b100011, 0, 0, 4, 1, F, Z,
                cw(0,0,2'b00,0,0,2'b00,0,0,2'b00,2'b01,2'b00,2'b00,0,0),
                cw(0,0,2'b01,0,1,2'b00,0,0,2'b00,2'b01,2'b00,2'b00,0,0), Z);
        add_vec("slt", 6'b000000, 6'b101010, 0, 0, 4, 1, F, Z,
                cw(0,0,2'b00,0,0,2'b00,0,0,2'b00,2'b11,2'b00,2'b00,0,0),
                cw(0,0,2'b01,0,1,2'b00,0,0,2'b00,2'b11,2'b00,2'b00,0,0), Z);
        add_vec("lw", 6'b100011, 6'b000000, 0, 0, 5, 1, F, Z, E_LS, E_LS,
                cw(0,0,2'b00,1,1,2'b01,0,0,2'b01,2'b00,2'b00,2'b00,0,0));
        add_vec("sw", 6'b101011, 6'b000000, 0, 0, 4, 1, F, Z, E_LS,
                cw(0,0,2'b00,1,0,2'b00,1,0,2'b01,2'b00,2'b00,2'b00,0,0), Z);
        add_vec("beq_z1", 6'b000100, 6'b000000, 1, 0, 3, 1, F, Z, E_BEQ, Z, Z);
        add_vec("beq_z0", 6'b000100, 6'b000000, 0, 0, 3, 1, F, Z, E_BEQ, Z, Z);
        add_vec("jal", 6'b000011, 6'b000000, 0, 0, 2, 1, F,
                cw(1,0,2'b11,0,1,2'b10,0,0,2'b00,2'b00,2'b10,2'b00,0,0), Z, Z, Z);
        add_vec("illegal_op", 6'b111111, 6'b000000, 0, 0, 2, 0, F,
                cw(0,0,2'b00,0,0,2'b00,0,0,2'b00,2'b00,2'b00,2'b00,0,1), Z, Z, Z);
        add_vec("j", 6'b000010, 6'b000000, 0, 0, 2, 1, F,
                cw(1,0,2'b00,0,0,2'b00,0,0,2'b00,2'b00,2'b10,2'b00,0,0), Z, Z, Z);
        add_vec("jr", 6'b000000, 6'b001000, 0, 0, 2, 1, F,
                cw(1,0,2'b00,0,0,2'b00,0,0,2'b00,2'b00,2'b11,2'b00,0,0), Z, Z, Z);
        add_vec("ori", 6'b001101, 6'b000000, 0, 0, 4, 1, F, Z, E_ORI,
                cw(0,0,2'b00,1,1,2'b00,0,0,2'b00,2'b10,2'b00,2'b00,0,0), Z);
        add_vec("illegal_fn", 6'b000000, 6'b111111, 0, 0, 2, 0, F,
                cw(0,0,2'b00,0,0,2'b00,0,0,2'b00,2'b00,2'b00,2'b00,0,1), Z, Z, Z);
        add_vec("lui", 6'b001111, 6'b000000, 0, 0, 4, 1, F, Z, E_LUI,
                cw(0,0,2'b00,1,1,2'b00,0,0,2'b10,2'b00,2'b00,2'b01,0,0), Z);
        add_vec("addi_f1", 6'b001000, 6'b000000, 0, 1, 4, 1, F, Z, E_ADDI,
                cw(0,0,2'b10,1,1,2'b00,0,0,2'b01,2'b00,2'b00,2'b00,1,0), Z);
        add_vec("addi_f0", 6'b001000, 6'b000000, 0, 0, 4, 1, F, Z, E_ADDI,
                cw(0,0,2'b00,1,1,2'b00,0,0,2'b01,2'b00,2'b00,2'b00,1,0), Z);

        rst           = 1'b0;
        bus_if.opcode = 6'b000000;
        bus_if.funct  = 6'b100001;
        bus_if.zero   = 1'b0;
        bus_if.flow   = 1'b0;

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("reset[c%0d]", k), Z, 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < nv; i++) run_vec(i);

        // addi flow change inside WB must reach RegDst without a clock.
        bus_if.opcode = 6'b001000;
        bus_if.funct  = 6'b000000;
        bus_if.flow   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("addi_comb[c%0d]", k), (k == 0) ? F : ((k == 1) ? Z : E_ADDI), exp_ic);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("addi_comb_wb_f0", cw(0,0,2'b00,1,1,2'b00,0,0,2'b01,2'b00,2'b00,2'b00,1,0), exp_ic);
        bus_if.flow = 1'b1;
        #1;
        check("addi_comb_wb_f1", cw(0,0,2'b10,1,1,2'b00,0,0,2'b01,2'b00,2'b00,2'b00,1,0), exp_ic);
        @(posedge clk);
        #1;
        exp_ic++;
        bus_if.flow = 1'b0;

        // Abort an sw in EXEC: outputs drop at once, counter clears, restart in FETCH.
        bus_if.opcode = 6'b101011;
        @(negedge clk);
        check("abort_fetch", F, exp_ic);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_decode", Z, exp_ic);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_exec", E_LS, exp_ic);
        #1 rst = 1'b0;
        #1;
        check("abort_rst_low", Z, 32'd0);
        @(posedge clk);
        #1;
        check("abort_rst_hold", Z, 32'd0);
        rst    = 1'b1;
        exp_ic = 0;
        @(negedge clk);
        check("abort_refetch", F, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_redecode_sw", Z, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_reexec_sw", E_LS, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_mem_sw", cw(0,0,2'b00,1,0,2'b00,1,0,2'b01,2'b00,2'b00,2'b00,0,0), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_sw_fetch", F, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS core: the producer side of the datapath control interface. It consumes opcode/funct and the ALU zero/flow flags, and drives every datapath control signal through a FETCH/DECODE/EXEC/MEM/WB state machine. It adds PC and instruction-register write enables, an illegal-instruction pulse and a retired-instruction counter. It lets the datapath share one ALU and memory port across cycles.

## Interface

- No parameters.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- flow  in  1  ALU signed-overflow flag.
- PCWr  out  1  PC register write enable.
- IRWr  out  1  instruction register write enable.
- RegDst  out  2  00 rt, 01 rd, 10 $30, 11 $31.
- ALUSrc  out  1  0 rt data, 1 extended immediate.
- RegWr  out  1  GPR write enable.
- MemtoReg  out  2  00 ALU, 01 DM, 10 pc_4.
- MemWrite  out  1  DM write enable.
- nPC_sel  out  1  1 = conditional branch, qualified by zero inside npc.
- Ext_Op  out  2  00 zero-extend, 01 sign-extend, 10 shift left by 16.
- ALUctr  out  2  00 add, 01 sub, 10 or, 11 slt.
- pc_sel  out  2  00 pc+4, 01 branch, 10 j/jal target, 11 jr (rs).
- alu_sel  out  2  00 normal, 01 pass din2 (lui), 10/11 reserved; always driven 00 otherwise.
- addi_sel  out  1  1 during an addi instruction.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode/funct.
- icount  out  32  retired-instruction counter.

## Operation

- Supported instructions:
  - R-type (opcode 000000): addu 100001, subu 100011, slt 101010, jr 001000.
  - ori 001101, lui 001111, addi 001000, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States are FETCH (0), DECODE (1), EXEC (2), MEM (3), WB (4). The state register is 3 bits; unused codes return to FETCH on the next edge.
- FETCH: IRWr=1, PCWr=1, pc_sel=00. Next state DECODE.
- DECODE:
  - j: PCWr=1, pc_sel=10.
  - jal: PCWr=1, pc_sel=10, RegWr=1, RegDst=11, MemtoReg=10.
  - jr: PCWr=1, pc_sel=11.
  - j, jal and jr go to FETCH. Every other supported instruction goes to EXEC.
  - Unsupported opcode/funct: illegal=1, no enables asserted, go to FETCH.
- EXEC:
  - R-type: ALUSrc=0; ALUctr is 00 addu, 01 subu, 11 slt. Next state WB.
  - ori: ALUSrc=1, Ext_Op=00, ALUctr=10. Next state WB.
  - lui: ALUSrc=1, Ext_Op=10, alu_sel=01. Next state WB.
  - addi: ALUSrc=1, Ext_Op=01, ALUctr=00, addi_sel=1. Next state WB.
  - lw/sw: ALUSrc=1, Ext_Op=01, ALUctr=00. Next state MEM.
  - beq: ALUSrc=0, ALUctr=01, nPC_sel=1, pc_sel=01, PCWr=1. Next state FETCH. The npc block selects the target only when zero=1.
- MEM: ALU controls are held from EXEC.
  - sw: MemWrite=1, next state FETCH.
  - lw: next state WB.
- WB: ALU controls are held from EXEC and RegWr=1.
  - R-type: RegDst=01, MemtoReg=00.
  - ori/lui: RegDst=00, MemtoReg=00.
  - lw: RegDst=00, MemtoReg=01.
  - addi: RegDst=10 if flow=1, else 00; MemtoReg=00; addi_sel=1.
  - Next state FETCH.
- icount increments by 1 on the clock edge leaving any state that transitions to FETCH, excluding illegal instructions. It wraps from 0xFFFFFFFF to 0.
- All outputs not listed for a state are 0.

## Timing

- Cycles per instruction: j/jal/jr 2, beq 3, R-type/ori/lui/addi 4, sw 4, lw 5.
- Control outputs are Moore-style: a function of state and the opcode/funct from the instruction register, which only changes on FETCH edges. In WB, flow is the one exception and has a combinational path to RegDst.
- Reset (rst=0):
  - state=FETCH, icount=0.
  - All outputs forced to 0 while rst is low, including the FETCH PCWr/IRWr.
- Reset asserted mid-instruction: state aborts immediately; no write enable may glitch high.
- First FETCH enables assert in the first cycle after rst deasserts.
- illegal is high for exactly one cycle (the DECODE cycle). There are no other side effects.

## Test plan

- Reset: hold rst=0 for 3 cycles → all outputs 0, icount=0. Release → PCWr=IRWr=1 in that cycle, DECODE in the next.
- addu then subu then slt (funct 100001/100011/101010) → 4 cycles each. WB shows RegWr=1, RegDst=01, with ALUctr 00/01/11 respectively; icount=3.
- lw then sw → lw takes 5 cycles with MemtoReg=01 in WB; sw takes 4 cycles with MemWrite=1 only in MEM; RegWr never asserts for sw.
- beq with zero=1 and again with zero=0 → both take 3 cycles with EXEC showing PCWr=1, nPC_sel=1, pc_sel=01.
- jal → 2 cycles; DECODE shows RegWr=1, RegDst=11, MemtoReg=10, pc_sel=10, PCWr=1.
- addi with flow=1 → WB shows RegDst=10, addi_sel=1. Opcode 111111 → illegal pulse of 1 cycle, back in FETCH, icount unchanged.
